// File: rtl/uart_mem_cmd_parser_pkg.sv
// Shared constants, state encodings and payload types for the UART memory command parser.
package uart_mem_cmd_parser_pkg;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned DATA_W             = 32;
    localparam int unsigned STATE_W            = 3;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1_000_000;

    localparam logic [BYTE_W-1:0] WRITE_CMD_DEF = 8'h56;
    localparam logic [BYTE_W-1:0] READ_CMD_DEF  = 8'h55;
    localparam logic [BYTE_W-1:0] ACK_BYTE_DEF  = 8'hAA;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_ADDR  = 3'd1;
    localparam logic [STATE_W-1:0] ST_WDATA = 3'd2;
    localparam logic [STATE_W-1:0] ST_MEM   = 3'd3;
    localparam logic [STATE_W-1:0] ST_TX    = 3'd4;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Little-endian byte lane select: idx 0 returns bits [7:0].
    function automatic logic [BYTE_W-1:0] byte_of(input logic [DATA_W-1:0] word,
                                                  input logic [1:0]        idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/byte_timeout_counter.sv
// Inter-byte idle counter; expired is asserted while enabled and the count sits at TIMEOUT_CYCLES-1.
module byte_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned     CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = en && (count == LAST);

endmodule

// File: rtl/uart_mem_cmd_parser.sv
// Byte-level command parser: UART frames in, one 32-bit SRAM request per frame, response bytes out.
module uart_mem_cmd_parser
    import uart_mem_cmd_parser_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [BYTE_W-1:0] WRITE_CMD      = WRITE_CMD_DEF,
    parameter logic [BYTE_W-1:0] READ_CMD       = READ_CMD_DEF,
    parameter logic [BYTE_W-1:0] ACK_BYTE       = ACK_BYTE_DEF
) (
    input  logic              clk50MHz,
    input  logic              rst_L,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              frame_err,
    output logic [BYTE_W-1:0] debug_out
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    mem_cmd_t           req_q, req_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               mem_req_q, mem_req_d;
    logic               frame_err_q, frame_err_d;

    logic in_frame;
    logic expired;

    // Idle counting only matters between bytes of a frame; outside it the counter is held at zero.
    assign in_frame = (state_q == ST_ADDR) || (state_q == ST_WDATA);

    byte_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk50MHz),
        .rst_n  (rst_L),
        .clr    (rx_valid || !in_frame),
        .en     (in_frame),
        .expired(expired)
    );

    always_ff @(posedge clk50MHz or negedge rst_L) begin
        if (!rst_L) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            req_q       <= '0;
            rdata_q     <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            req_q       <= req_d;
            rdata_q     <= rdata_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            mem_req_q   <= mem_req_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        req_d       = req_q;
        rdata_d     = rdata_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        mem_req_d   = mem_req_q;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == WRITE_CMD)) begin
                    state_d    = ST_ADDR;
                    byte_cnt_d = 2'd0;
                    req_d.we   = 1'b1;
                end else if (rx_valid && (rx_data == READ_CMD)) begin
                    state_d    = ST_ADDR;
                    byte_cnt_d = 2'd0;
                    req_d.we   = 1'b0;
                end
            end

            // Timeout takes priority over a byte arriving in the same cycle.
            ST_ADDR: begin
                if (expired) begin
                    state_d     = ST_IDLE;
                    byte_cnt_d  = 2'd0;
                    frame_err_d = 1'b1;
                end else if (rx_valid) begin
                    req_d.addr = {rx_data, req_q.addr[DATA_W-1:BYTE_W]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (req_q.we) begin
                            state_d = ST_WDATA;
                        end else begin
                            state_d   = ST_MEM;
                            mem_req_d = 1'b1;
                        end
                    end
                end
            end

            ST_WDATA: begin
                if (expired) begin
                    state_d     = ST_IDLE;
                    byte_cnt_d  = 2'd0;
                    frame_err_d = 1'b1;
                end else if (rx_valid) begin
                    req_d.wdata = {rx_data, req_q.wdata[DATA_W-1:BYTE_W]};
                    byte_cnt_d  = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d   = ST_MEM;
                        mem_req_d = 1'b1;
                    end
                end
            end

            ST_MEM: begin
                frame_err_d = rx_valid;
                if (mem_done) begin
                    state_d    = ST_TX;
                    mem_req_d  = 1'b0;
                    rdata_d    = mem_rdata;
                    byte_cnt_d = 2'd0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = req_q.we ? ACK_BYTE : byte_of(mem_rdata, 2'd0);
                end
            end

            // byte_cnt indexes the read-data lane currently presented.
            ST_TX: begin
                frame_err_d = rx_valid;
                if (tx_valid_q && tx_ready) begin
                    if (req_q.we || (byte_cnt_q == 2'd3)) begin
                        state_d    = ST_IDLE;
                        byte_cnt_d = 2'd0;
                        tx_valid_d = 1'b0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        tx_data_d  = byte_of(rdata_q, byte_cnt_q + 2'd1);
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                byte_cnt_d = 2'd0;
                tx_valid_d = 1'b0;
                mem_req_d  = 1'b0;
            end
        endcase
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = req_q.we;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign frame_err = frame_err_q;
    assign debug_out = {3'b000, state_q, byte_cnt_q};

endmodule
